// File: rtl/difference_decoder.sv
// ============================================================================
// difference_decoder : rebuilds mask +/- difference values and streams them.
// Optional clamp of out-of-range results: DIFF_DECODER_OVF_CLAMP_EN. Rev 1.0
// ============================================================================
`default_nettype none

module difference_decoder (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_diff,
    input  logic       wr_neg,
    input  logic       start,
    input  logic [2:0] start_addr,
    input  logic [2:0] count,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [2:0] out_index,
    output logic [7:0] out_number,
    output logic       out_ovf,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        PRESENT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] cur_addr_q, cur_addr_d;
    logic [3:0] remaining_q, remaining_d;
    logic       out_valid_q, out_valid_d;
    logic [2:0] out_index_q, out_index_d;
    logic [7:0] out_number_q, out_number_d;
    logic       out_ovf_q, out_ovf_d;
    logic       done_q, done_d;
    logic [8:0] entry_q [8];

    logic [8:0] rd_entry_w;
    logic [7:0] mask_w;
    logic [7:0] number_w;
    logic       ovf_w;

    assign rd_entry_w = entry_q[cur_addr_q];

    always_comb begin
        mask_w = 8'h00;
        case (cur_addr_q)
            3'd0: mask_w = 8'h00;
            3'd1: mask_w = 8'h55;
            3'd2: mask_w = 8'hAA;
            3'd3: mask_w = 8'h33;
            3'd4: mask_w = 8'hCC;
            3'd5: mask_w = 8'h0F;
            3'd6: mask_w = 8'hF0;
            3'd7: mask_w = 8'hFF;
            default: mask_w = 8'h00;
        endcase
    end

`ifdef DIFF_DECODER_OVF_CLAMP_EN
    // Two guard bits: bit 9 flags a negative result, bit 8 a result above FF.
    logic [9:0] sum_w;

    always_comb begin
        if (rd_entry_w[8]) begin
            sum_w = {2'b00, mask_w} - {2'b00, rd_entry_w[7:0]};
        end else begin
            sum_w = {2'b00, mask_w} + {2'b00, rd_entry_w[7:0]};
        end
        number_w = sum_w[7:0];
        ovf_w    = 1'b0;
        if (sum_w[9]) begin
            number_w = 8'h00;
            ovf_w    = 1'b1;
        end else if (sum_w[8]) begin
            number_w = 8'hFF;
            ovf_w    = 1'b1;
        end
    end
`else
    always_comb begin
        if (rd_entry_w[8]) begin
            number_w = mask_w - rd_entry_w[7:0];
        end else begin
            number_w = mask_w + rd_entry_w[7:0];
        end
        ovf_w = 1'b0;
    end
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < 8; i++) begin
                entry_q[i] <= 9'h000;
            end
        end else if (wr_en) begin
            entry_q[wr_addr] <= {wr_neg, wr_diff};
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            cur_addr_q   <= 3'd0;
            remaining_q  <= 4'd0;
            out_valid_q  <= 1'b0;
            out_index_q  <= 3'd0;
            out_number_q <= 8'h00;
            out_ovf_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            remaining_q  <= remaining_d;
            out_valid_q  <= out_valid_d;
            out_index_q  <= out_index_d;
            out_number_q <= out_number_d;
            out_ovf_q    <= out_ovf_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        remaining_d  = remaining_q;
        out_valid_d  = out_valid_q;
        out_index_d  = out_index_q;
        out_number_d = out_number_q;
        out_ovf_d    = out_ovf_q;
        done_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cur_addr_d  = start_addr;
                    remaining_d = (count == 3'd0) ? 4'd8 : {1'b0, count};
                    state_d     = FETCH;
                end
            end
            FETCH: begin
                out_valid_d  = 1'b1;
                out_index_d  = cur_addr_q;
                out_number_d = number_w;
                out_ovf_d    = ovf_w;
                state_d      = PRESENT;
            end
            PRESENT: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    if (remaining_q == 4'd1) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        remaining_d = remaining_q - 4'd1;
                        cur_addr_d  = cur_addr_q + 3'd1;
                        state_d     = FETCH;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out_valid  = out_valid_q;
    assign out_index  = out_index_q;
    assign out_number = out_number_q;
    assign out_ovf    = out_ovf_q;
    assign done       = done_q;
    assign busy       = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_difference_decoder.sv
// ============================================================================
// tb_difference_decoder : randomized self-checking bench for difference_decoder.
// ============================================================================
`default_nettype none

module tb_difference_decoder;

    logic       CLK;
    logic       RST_N;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_diff;
    logic       wr_neg;
    logic       start;
    logic [2:0] start_addr;
    logic [2:0] count;
    logic       out_ready;
    logic       out_valid;
    logic [2:0] out_index;
    logic [7:0] out_number;
    logic       out_ovf;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    int         mask_tbl [8] = '{8'h00, 8'h55, 8'hAA, 8'h33, 8'hCC, 8'h0F, 8'hF0, 8'hFF};
    logic [7:0] m_diff [8];
    logic       m_neg  [8];

    logic [7:0] q_num [$];
    logic [2:0] q_idx [$];
    logic       q_ovf [$];

    difference_decoder dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_diff    (wr_diff),
        .wr_neg     (wr_neg),
        .start      (start),
        .start_addr (start_addr),
        .count      (count),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_index  (out_index),
        .out_number (out_number),
        .out_ovf    (out_ovf),
        .busy       (busy),
        .done       (done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference: original = mask +/- diff as an unbounded integer.
    function automatic logic [8:0] model_item(input int idx);
        int s;
        int d;
        d = int'(m_diff[idx]);
        s = m_neg[idx] ? (mask_tbl[idx] - d) : (mask_tbl[idx] + d);
`ifdef DIFF_DECODER_OVF_CLAMP_EN
        if (s > 255) return {1'b1, 8'hFF};
        if (s < 0)   return {1'b1, 8'h00};
        return {1'b0, 8'(s)};
`else
        return {1'b0, 8'(s & 255)};
`endif
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            m_diff[i] = 8'h00;
            m_neg[i]  = 1'b0;
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic n, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_neg = n; wr_diff = d;
        @(negedge CLK);
        wr_en = 1'b0;
        m_neg[a]  = n;
        m_diff[a] = d;
    endtask

    // Runs one decode from a negedge; leaves at the negedge after done falls.
    task automatic do_run(input logic [2:0] sa, input logic [2:0] cnt,
                          input bit rnd_ready, input bit poke);
        int n, got, cyc, idx;
        logic pv, pr;
        logic [2:0] pi;
        logic [7:0] pn;
        logic [8:0] e;
        n = (cnt == 3'd0) ? 8 : int'(cnt);
        got = 0; cyc = 0; pv = 1'b0; pr = 1'b0; pi = 3'd0; pn = 8'h00;
        q_num.delete(); q_idx.delete(); q_ovf.delete();
        start = 1'b1; start_addr = sa; count = cnt; out_ready = 1'b0;
        @(negedge CLK);
        start = 1'b0;
        while (got < n && cyc < 300) begin
            cyc++;
            if (pv && !pr) begin
                checks++;
                if (out_valid !== 1'b1 || out_index !== pi || out_number !== pn) begin
                    failures++;
                    $display("FAIL hold: valid=%b idx=%0d num=%h expected idx=%0d num=%h",
                             out_valid, out_index, out_number, pi, pn);
                end
            end
            checks++;
            if (done !== 1'b0) begin
                failures++;
                $display("FAIL early_done: done=%b expected 0 at item %0d", done, got);
            end
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (poke) begin
                start      = 1'($urandom_range(0, 1));
                start_addr = 3'($urandom);
                count      = 3'($urandom);
            end
            if (out_valid && out_ready) begin
                idx = (int'(sa) + got) % 8;
                e = model_item(idx);
                checks++;
                if (out_index !== 3'(idx) || out_number !== e[7:0] || out_ovf !== e[8]) begin
                    failures++;
                    $display("FAIL item: idx=%0d num=%h ovf=%b expected idx=%0d num=%h ovf=%b",
                             out_index, out_number, out_ovf, idx, e[7:0], e[8]);
                end
                q_num.push_back(out_number);
                q_idx.push_back(out_index);
                q_ovf.push_back(out_ovf);
                got++;
            end
            pv = out_valid; pr = out_ready; pi = out_index; pn = out_number;
            @(negedge CLK);
        end
        start = 1'b0; out_ready = 1'b0;
        checks++;
        if (got != n) begin
            failures++;
            $display("FAIL run_timeout: got %0d items expected %0d", got, n);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse: done=%b busy=%b valid=%b expected 1 1 0",
                     done, busy, out_valid);
        end
        @(negedge CLK);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL done_end: done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        checks++;
        if (out_valid !== 1'b0 || out_index !== 3'd0 || out_number !== 8'h00 ||
            out_ovf !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL %s: valid=%b idx=%0d num=%h ovf=%b busy=%b done=%b expected all 0",
                     tag, out_valid, out_index, out_number, out_ovf, busy, done);
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        #1;
        check_outputs_zero("reset_assert");
        model_clear();
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        check_outputs_zero("reset_release");
    endtask

    task automatic test_basic();
        wr(3'd1, 1'b0, 8'h10);
        do_run(3'd1, 3'd1, 1'b0, 1'b0);
        checks++;
        if (q_num[0] !== 8'h65 || q_idx[0] !== 3'd1) begin
            failures++;
            $display("FAIL basic_add: num=%h idx=%0d expected 65 1", q_num[0], q_idx[0]);
        end
        wr(3'd1, 1'b1, 8'h10);
        do_run(3'd1, 3'd1, 1'b0, 1'b0);
        checks++;
        if (q_num[0] !== 8'h45) begin
            failures++;
            $display("FAIL basic_sub: num=%h expected 45", q_num[0]);
        end
    endtask

    task automatic test_wraparound();
        logic [7:0] exp7;
        logic       ovf7;
`ifdef DIFF_DECODER_OVF_CLAMP_EN
        exp7 = 8'hFF; ovf7 = 1'b1;
`else
        exp7 = 8'h00; ovf7 = 1'b0;
`endif
        wr(3'd6, 1'b0, 8'h01);
        wr(3'd7, 1'b0, 8'h01);
        wr(3'd0, 1'b0, 8'h01);
        do_run(3'd6, 3'd3, 1'b0, 1'b0);
        checks++;
        if (q_num[0] !== 8'hF1 || q_num[1] !== exp7 || q_ovf[1] !== ovf7 ||
            q_num[2] !== 8'h01 || q_idx[2] !== 3'd0) begin
            failures++;
            $display("FAIL wrap: %h %h(ovf %b) %h idx2=%0d expected F1 %h(ovf %b) 01 idx2=0",
                     q_num[0], q_num[1], q_ovf[1], q_num[2], q_idx[2], exp7, ovf7);
        end
    endtask

    task automatic test_underflow();
        logic [7:0] exp0;
        logic       ovf0;
`ifdef DIFF_DECODER_OVF_CLAMP_EN
        exp0 = 8'h00; ovf0 = 1'b1;
`else
        exp0 = 8'hFE; ovf0 = 1'b0;
`endif
        wr(3'd0, 1'b1, 8'h02);
        do_run(3'd7, 3'd2, 1'b0, 1'b0);
        checks++;
        if (q_num[1] !== exp0 || q_ovf[1] !== ovf0) begin
            failures++;
            $display("FAIL underflow: num=%h ovf=%b expected %h %b", q_num[1], q_ovf[1], exp0, ovf0);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        logic [8:0] e;
        logic [2:0] hi;
        logic [7:0] hn;
        wr(3'd2, 1'b0, 8'h03);
        wr(3'd3, 1'b1, 8'h03);
        start = 1'b1; start_addr = 3'd2; count = 3'd2; out_ready = 1'b0;
        @(negedge CLK);
        start = 1'b0;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 10) begin
            cyc++;
            @(negedge CLK);
        end
        e = model_item(2);
        checks++;
        if (out_valid !== 1'b1 || out_index !== 3'd2 || out_number !== e[7:0]) begin
            failures++;
            $display("FAIL bp_first: valid=%b idx=%0d num=%h expected 1 2 %h",
                     out_valid, out_index, out_number, e[7:0]);
        end
        hi = out_index; hn = out_number;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            checks++;
            if (out_valid !== 1'b1 || out_index !== hi || out_number !== hn) begin
                failures++;
                $display("FAIL bp_hold: cycle %0d valid=%b idx=%0d num=%h expected 1 %0d %h",
                         i, out_valid, out_index, out_number, hi, hn);
            end
        end
        out_ready = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_drop: valid=%b expected 0", out_valid);
        end
        @(negedge CLK);
        e = model_item(3);
        checks++;
        if (out_valid !== 1'b1 || out_index !== 3'd3 || out_number !== e[7:0]) begin
            failures++;
            $display("FAIL bp_next: valid=%b idx=%0d num=%h expected 1 3 %h",
                     out_valid, out_index, out_number, e[7:0]);
        end
        out_ready = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL bp_done: done=%b expected 1", done);
        end
        @(negedge CLK);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_idle: done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_write_collision();
        logic [8:0] e;
        wr(3'd4, 1'b0, 8'h05);
        start = 1'b1; start_addr = 3'd4; count = 3'd1; out_ready = 1'b0;
        @(negedge CLK);
        start = 1'b0;
        wr_en = 1'b1; wr_addr = 3'd4; wr_neg = 1'b0; wr_diff = 8'h20;
        @(negedge CLK);
        wr_en = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_number !== 8'hD1) begin
            failures++;
            $display("FAIL same_cycle_old: valid=%b num=%h expected 1 D1", out_valid, out_number);
        end
        wr(3'd4, 1'b1, 8'h30);
        checks++;
        if (out_number !== 8'hD1 || out_index !== 3'd4) begin
            failures++;
            $display("FAIL held_vs_write: num=%h idx=%0d expected D1 4", out_number, out_index);
        end
        out_ready = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0;
        @(negedge CLK);
        e = model_item(4);
        do_run(3'd4, 3'd1, 1'b0, 1'b0);
        checks++;
        if (q_num[0] !== 8'h9C || e[7:0] !== 8'h9C) begin
            failures++;
            $display("FAIL new_value_seen: num=%h model=%h expected 9C", q_num[0], e[7:0]);
        end
    endtask

    task automatic test_full_count0();
        test_reset();
        do_run(3'd3, 3'd0, 1'b1, 1'b1);
        checks++;
        if (q_num.size() != 8) begin
            failures++;
            $display("FAIL full_len: got %0d items expected 8", q_num.size());
        end
        for (int i = 0; i < 8 && i < q_num.size(); i++) begin
            checks++;
            if (q_idx[i] !== 3'((3 + i) % 8) || q_num[i] !== 8'(mask_tbl[(3 + i) % 8])) begin
                failures++;
                $display("FAIL full_item: idx=%0d num=%h expected idx=%0d num=%h",
                         q_idx[i], q_num[i], (3 + i) % 8, mask_tbl[(3 + i) % 8]);
            end
        end
    endtask

    task automatic test_reset_midrun();
        int got;
        int cyc;
        wr(3'd0, 1'b0, 8'h05);
        wr(3'd1, 1'b1, 8'h07);
        wr(3'd5, 1'b0, 8'h11);
        start = 1'b1; start_addr = 3'd0; count = 3'd0; out_ready = 1'b0;
        @(negedge CLK);
        start = 1'b0; out_ready = 1'b1;
        got = 0; cyc = 0;
        while (cyc < 50) begin
            cyc++;
            if (out_valid === 1'b1) begin
                if (got == 2) break;
                got++;
            end
            @(negedge CLK);
        end
        checks++;
        if (got != 2 || out_valid !== 1'b1 || out_index !== 3'd2) begin
            failures++;
            $display("FAIL midrun_reach: got=%0d valid=%b idx=%0d expected 2 1 2",
                     got, out_valid, out_index);
        end
        out_ready = 1'b0;
        RST_N = 1'b0;
        #1;
        check_outputs_zero("midrun_reset");
        model_clear();
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            checks++;
            if (done !== 1'b0) begin
                failures++;
                $display("FAIL midrun_done: done=%b expected 0", done);
            end
        end
        RST_N = 1'b1;
        @(negedge CLK);
        do_run(3'd0, 3'd0, 1'b1, 1'b0);
        checks++;
        if (q_num[0] !== 8'h00 || q_num[1] !== 8'h55 || q_num[5] !== 8'h0F) begin
            failures++;
            $display("FAIL midrun_cleared: %h %h %h expected 00 55 0F", q_num[0], q_num[1], q_num[5]);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 20; it++) begin
            for (int w = 0; w < int'($urandom_range(1, 4)); w++) begin
                wr(3'($urandom), 1'($urandom), 8'($urandom));
            end
            do_run(3'($urandom), 3'($urandom), 1'b1, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        RST_N = 1'b0; wr_en = 1'b0; wr_addr = 3'd0; wr_diff = 8'h00; wr_neg = 1'b0;
        start = 1'b0; start_addr = 3'd0; count = 3'd0; out_ready = 1'b0;
        model_clear();
        @(negedge CLK);
        test_reset();
        test_basic();
        test_wraparound();
        test_underflow();
        test_backpressure();
        test_write_collision();
        test_full_count0();
        test_reset_midrun();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
